pkt_stats: RTL and testbench

PKT_STATS -- requirements
Module: pkt_stats

---
 rtl/dataplane_pkg.sv | 21 ++
 rtl/sat_counter.sv | 30 +++
 rtl/pkt_stats.sv | 167 ++++++++++++++++
 tb/tb_pkt_stats.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dataplane_pkg.sv
// Shared definitions for the packet statistics block: register offsets,
// CTRL bit positions and the packet state encoding.
package dataplane_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_PKT_CNT  = 5'h04;
  localparam logic [4:0] OFF_BYTE_CNT = 5'h08;
  localparam logic [4:0] OFF_DROP_CNT = 5'h0C;
  localparam logic [4:0] OFF_MAX_LEN  = 5'h10;
  localparam logic [4:0] OFF_STATUS   = 5'h14;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT  = 1;

endpackage

// File: rtl/sat_counter.sv
// Saturating accumulator: adds 'add' when 'inc' is high, sticks at all-ones,
// and returns to zero on reset or clear (clear wins over increment).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] add,
  output logic [W-1:0] count
);

  logic [W:0] sum;

  // Widened sum so the carry-out flags overflow.
  always_comb begin
    sum = {1'b0, count} + {1'b0, add};
  end

  // Accumulate with saturation; clear has priority.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/pkt_stats.sv
// Packet statistics tap: forwards or drops whole AXI-Stream packets depending
// on CTRL.enable latched at packet start, and keeps saturating counters that
// are readable through a small register window.
module pkt_stats
  import dataplane_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic                m_tvalid,
  input  logic                m_tready,
  input  logic [31:0]         waddr,
  input  logic [31:0]         wdata,
  input  logic                we,
  output logic                wdone,
  input  logic [31:0]         raddr,
  input  logic                re,
  output logic [31:0]         rdata,
  output logic                rdone
);

  localparam int KEEP_W = DATA_W / 8;

  state_t      state;
  logic        enable;
  logic        fwd_mode;
  logic        accepted;
  logic        fwd_beat;
  logic        drop_beat;
  logic        wr_ctrl;
  logic        clear;
  logic [31:0] beat_bytes;
  logic [31:0] pkt_cnt;
  logic [31:0] byte_cnt;
  logic [31:0] drop_cnt;
  logic [31:0] cur_len;
  logic [31:0] max_len;
  logic [32:0] len_sum;
  logic [31:0] len_total;
  logic [31:0] rd_val;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:2];

  // A packet in progress keeps its decision; at IDLE the live enable decides.
  always_comb begin
    fwd_mode  = (state == ST_PASS) || ((state == ST_IDLE) && enable);
    m_tdata   = s_tdata;
    m_tkeep   = s_tkeep;
    m_tlast   = s_tlast;
    m_tvalid  = s_tvalid && fwd_mode;
    s_tready  = fwd_mode ? m_tready : 1'b1;
    accepted  = s_tvalid && s_tready;
    fwd_beat  = accepted && fwd_mode;
    drop_beat = accepted && !fwd_mode;
    wr_ctrl   = we && (waddr[31:5] == BASE_ADDR[31:5]) && (waddr[4:0] == OFF_CTRL);
    clear     = wr_ctrl && wdata[CTRL_CLEAR_BIT];
  end

  // Byte count of the beat: tkeep bits need not be contiguous.
  always_comb begin
    beat_bytes = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      beat_bytes = beat_bytes + 32'(s_tkeep[i]);
    end
  end

  // Packet length including the current beat, saturated.
  always_comb begin
    len_sum   = {1'b0, cur_len} + {1'b0, beat_bytes};
    len_total = len_sum[32] ? '1 : len_sum[31:0];
  end

  // Packet state machine; advances only on accepted beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (accepted) begin
      if (s_tlast) begin
        state <= ST_IDLE;
      end else if (state == ST_IDLE) begin
        state <= enable ? ST_PASS : ST_DROP;
      end
    end
  end

  // CTRL register: enable is stored, clear is a write-one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable <= 1'b0;
    end else if (wr_ctrl) begin
      enable <= wdata[CTRL_ENABLE_BIT];
    end
  end

  sat_counter #(.W(32)) u_pkt_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(fwd_beat && s_tlast),
    .add(32'd1), .count(pkt_cnt)
  );

  sat_counter #(.W(32)) u_byte_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(fwd_beat),
    .add(beat_bytes), .count(byte_cnt)
  );

  sat_counter #(.W(32)) u_drop_cnt (
    .clk(clk), .rst(rst), .clr(clear), .inc(drop_beat && s_tlast),
    .add(32'd1), .count(drop_cnt)
  );

  // Running length restarts after each forwarded tlast beat.
  sat_counter #(.W(32)) u_cur_len (
    .clk(clk), .rst(rst), .clr(clear || (fwd_beat && s_tlast)), .inc(fwd_beat),
    .add(beat_bytes), .count(cur_len)
  );

  // Longest forwarded packet seen since reset or clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      max_len <= '0;
    end else if (fwd_beat && s_tlast && (len_total > max_len)) begin
      max_len <= len_total;
    end
  end

  // Read mux over the current (pre-update) register values.
  always_comb begin
    rd_val = '0;
    if (raddr[31:5] == BASE_ADDR[31:5]) begin
      case (raddr[4:0])
        OFF_CTRL:     rd_val = {31'd0, enable};
        OFF_PKT_CNT:  rd_val = pkt_cnt;
        OFF_BYTE_CNT: rd_val = byte_cnt;
        OFF_DROP_CNT: rd_val = drop_cnt;
        OFF_MAX_LEN:  rd_val = max_len;
        OFF_STATUS:   rd_val = {30'd0, state};
        default:      rd_val = '0;
      endcase
    end
  end

  // Register-bus handshakes; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdone <= 1'b0;
      rdone <= 1'b0;
      rdata <= '0;
    end else begin
      wdone <= we;
      rdone <= re;
      if (re) begin
        rdata <= rd_val;
      end
    end
  end

endmodule

// File: tb/tb_pkt_stats.sv
// Directed bench for pkt_stats with hand-computed expected values.
module tb_pkt_stats;
  import dataplane_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        wdone;
  logic [31:0] raddr = '0;
  logic        re = 1'b0;
  logic [31:0] rdata;
  logic        rdone;

  int checks = 0;
  int errors = 0;

  pkt_stats #(.DATA_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .waddr(waddr), .wdata(wdata), .we(we), .wdone(wdone),
    .raddr(raddr), .re(re), .rdata(rdata), .rdone(rdone)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    we = 1'b1; waddr = BASE + 32'(off); wdata = d;
  endtask

  task automatic rd(input logic [4:0] off);
    re = 1'b1; raddr = BASE + 32'(off);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    s_tvalid = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] off, input logic [31:0] d);
    @(negedge clk); wr(off, d); tick();
    check("wdone", 32'(wdone), 32'd1);
  endtask

  task automatic check_reg(input string tag, input logic [4:0] off, input logic [31:0] exp);
    @(negedge clk); rd(off); tick();
    check({tag, ".rdone"}, 32'(rdone), 32'd1);
    check(tag, rdata, exp);
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic fwd);
    @(negedge clk); beat(d, k, l); #1;
    check("m_tvalid", 32'(m_tvalid), 32'(fwd));
    check("s_tready", 32'(s_tready), 32'd1);
    if (fwd) begin
      check("m_tdata", m_tdata, d);
      check("m_tkeep", 32'(m_tkeep), 32'(k));
      check("m_tlast", 32'(m_tlast), 32'(l));
    end
    tick();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst.wdone", 32'(wdone), 32'd0);
    check("rst.rdone", 32'(rdone), 32'd0);
    check("rst.rdata", rdata, 32'd0);
    check("rst.m_tvalid", 32'(m_tvalid), 32'd0);
    check_reg("rst.ctrl", OFF_CTRL, 32'd0);
    check_reg("rst.pkt", OFF_PKT_CNT, 32'd0);
    check_reg("rst.byte", OFF_BYTE_CNT, 32'd0);
    check_reg("rst.status", OFF_STATUS, 32'd0);

    // Forward 3-beat packet F,F,3
    write_reg(OFF_CTRL, 32'h1);
    send(32'hA0A0_0001, 4'hF, 1'b0, 1'b1);
    check_reg("pass.status", OFF_STATUS, 32'd1);
    send(32'hA0A0_0002, 4'hF, 1'b0, 1'b1);
    send(32'hA0A0_0003, 4'h3, 1'b1, 1'b1);
    check_reg("p1.pkt", OFF_PKT_CNT, 32'd1);
    check_reg("p1.byte", OFF_BYTE_CNT, 32'd10);
    check_reg("p1.max", OFF_MAX_LEN, 32'd10);
    check_reg("p1.drop", OFF_DROP_CNT, 32'd0);

    // Backpressure, then a single beat with non-contiguous keep 0101
    @(negedge clk); beat(32'hB0B0_0001, 4'h5, 1'b1); m_tready = 1'b0; #1;
    check("bp.s_tready", 32'(s_tready), 32'd0);
    check("bp.m_tvalid", 32'(m_tvalid), 32'd1);
    @(posedge clk); #1;
    m_tready = 1'b1;
    tick();
    check_reg("p2.pkt", OFF_PKT_CNT, 32'd2);
    check_reg("p2.byte", OFF_BYTE_CNT, 32'd12);
    check_reg("p2.max", OFF_MAX_LEN, 32'd10);

    // Drop a 2-beat packet, downstream not ready
    write_reg(OFF_CTRL, 32'h0);
    m_tready = 1'b0;
    send(32'hC0C0_0001, 4'hF, 1'b0, 1'b0);
    check_reg("drop.status", OFF_STATUS, 32'd2);
    send(32'hC0C0_0002, 4'hF, 1'b1, 1'b0);
    m_tready = 1'b1;
    check_reg("d1.drop", OFF_DROP_CNT, 32'd1);
    check_reg("d1.pkt", OFF_PKT_CNT, 32'd2);

    // Disable during beat 2 of a 4-beat forwarded packet
    write_reg(OFF_CTRL, 32'h1);
    send(32'hD0D0_0001, 4'hF, 1'b0, 1'b1);
    @(negedge clk); beat(32'hD0D0_0002, 4'hF, 1'b0); wr(OFF_CTRL, 32'h0); #1;
    check("mid.m_tvalid", 32'(m_tvalid), 32'd1);
    tick();
    check("mid.wdone", 32'(wdone), 32'd1);
    send(32'hD0D0_0003, 4'hF, 1'b0, 1'b1);
    send(32'hD0D0_0004, 4'hF, 1'b1, 1'b1);
    send(32'hE0E0_0001, 4'hF, 1'b1, 1'b0);
    check_reg("p3.pkt", OFF_PKT_CNT, 32'd3);
    check_reg("p3.byte", OFF_BYTE_CNT, 32'd28);
    check_reg("p3.max", OFF_MAX_LEN, 32'd16);
    check_reg("p3.drop", OFF_DROP_CNT, 32'd2);
    check_reg("p3.ctrl", OFF_CTRL, 32'd0);

    // rdata holds, unmapped read, write to RO register
    @(posedge clk); #1;
    check("hold.rdone", 32'(rdone), 32'd0);
    check("hold.rdata", rdata, 32'd0);
    check_reg("p3.pkt2", OFF_PKT_CNT, 32'd3);
    @(posedge clk); #1;
    check("hold2.rdata", rdata, 32'd3);
    check_reg("unmapped", 5'h1C, 32'd0);
    write_reg(OFF_PKT_CNT, 32'h55);
    @(posedge clk); #1;
    check("wdone.pulse", 32'(wdone), 32'd0);
    check_reg("ro.pkt", OFF_PKT_CNT, 32'd3);

    // Read concurrent with an update returns the old value
    write_reg(OFF_CTRL, 32'h1);
    @(negedge clk); beat(32'hF0F0_0001, 4'hF, 1'b1); rd(OFF_PKT_CNT); tick();
    check("rdw.rdata", rdata, 32'd3);
    check_reg("p4.pkt", OFF_PKT_CNT, 32'd4);

    // Simultaneous write and read
    @(negedge clk); wr(OFF_CTRL, 32'h1); rd(OFF_BYTE_CNT); tick();
    check("wr+rd.wdone", 32'(wdone), 32'd1);
    check("wr+rd.rdone", 32'(rdone), 32'd1);
    check("wr+rd.rdata", rdata, 32'd32);

    // Clear in the same cycle as a forwarded tlast beat
    @(negedge clk); beat(32'h1111_0001, 4'hF, 1'b1); wr(OFF_CTRL, 32'h3); tick();
    check_reg("clr.pkt", OFF_PKT_CNT, 32'd0);
    check_reg("clr.byte", OFF_BYTE_CNT, 32'd0);
    check_reg("clr.drop", OFF_DROP_CNT, 32'd0);
    check_reg("clr.max", OFF_MAX_LEN, 32'd0);
    check_reg("clr.ctrl", OFF_CTRL, 32'd1);

    // Clear mid-packet restarts the running length
    send(32'h2222_0001, 4'hF, 1'b0, 1'b1);
    write_reg(OFF_CTRL, 32'h3);
    send(32'h2222_0002, 4'h3, 1'b1, 1'b1);
    check_reg("clrmid.max", OFF_MAX_LEN, 32'd2);
    check_reg("clrmid.byte", OFF_BYTE_CNT, 32'd2);
    check_reg("clrmid.pkt", OFF_PKT_CNT, 32'd1);

    // Saturation of BYTE_CNT
    @(negedge clk);
    force dut.u_byte_cnt.count = 32'hFFFF_FFFE;
    #1 release dut.u_byte_cnt.count;
    send(32'h3333_0001, 4'hF, 1'b1, 1'b1);
    check_reg("sat.byte", OFF_BYTE_CNT, 32'hFFFF_FFFF);
    send(32'h3333_0002, 4'h1, 1'b1, 1'b1);
    check_reg("sat.byte2", OFF_BYTE_CNT, 32'hFFFF_FFFF);
    check_reg("sat.max", OFF_MAX_LEN, 32'd4);

    // Reset mid-packet: remainder becomes a new (dropped) packet
    send(32'h4444_0001, 4'hF, 1'b0, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reg("mrst.status", OFF_STATUS, 32'd0);
    check_reg("mrst.ctrl", OFF_CTRL, 32'd0);
    send(32'h4444_0002, 4'hF, 1'b1, 1'b0);
    check_reg("mrst.drop", OFF_DROP_CNT, 32'd1);
    check_reg("mrst.pkt", OFF_PKT_CNT, 32'd0);
    check_reg("mrst.byte", OFF_BYTE_CNT, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
